// File: rtl/avs_pkg.sv
// Shared constants for the AVS event-capture block: state encoding, channel
// indices and a constant-width helper.
package avs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam int unsigned CH_X = 0;
    localparam int unsigned CH_Y = 1;
    localparam int unsigned CH_P = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port
// with read-enable. Contents are deliberately not reset.
module capture_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 48,
    parameter int unsigned AW    = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read data holds its value while re is low; the drain logic relies on it.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/avs_event_capture.sv
// Event-triggered ring-buffer capture of multi-channel samples with a
// pre-trigger history, drained over a valid/ready stream.
module avs_event_capture
    import avs_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned PRE      = 16,
    parameter int unsigned BINW     = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic                      eventDetected,
    input  logic [BINW-1:0]           freqbin,
    input  logic                      arm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_first,
    output logic                      out_last,
    output logic [BINW-1:0]           out_freqbin,
    output logic [1:0]                state,
    output logic                      overrun
);

    localparam int unsigned DW    = CHANNELS * WIDTH;
    localparam int unsigned ADDRW = clog2(DEPTH);
    localparam int unsigned PCW   = clog2(PRE + 1);
    localparam int unsigned POST  = DEPTH - PRE - 1;

    state_e            state_q, state_d;
    logic [ADDRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDRW-1:0]  start_q, start_d;
    logic [ADDRW-1:0]  post_q, post_d;
    logic [ADDRW-1:0]  ld_cnt_q, ld_cnt_d;
    logic [ADDRW:0]    rd_cnt_q, rd_cnt_d;
    logic [PCW-1:0]    pre_q, pre_d;
    logic              ram_vld_q, ram_vld_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic              overrun_q, overrun_d;
    logic [BINW-1:0]   freqbin_q, freqbin_d;
    logic [DW-1:0]     out_data_q, out_data_d;

    logic              ram_we_c;
    logic              rd_en_c;
    logic              out_load_c;
    logic [ADDRW-1:0]  rd_addr_c;
    logic [DW-1:0]     ram_rdata;

    assign rd_addr_c = start_q + rd_cnt_q[ADDRW-1:0];

    capture_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (ADDRW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_c),
        .waddr (wr_ptr_q),
        .wdata (sample_in),
        .re    (rd_en_c),
        .raddr (rd_addr_c),
        .rdata (ram_rdata)
    );

    // Next-state: FSM, ring pointers and the two-stage drain pipeline
    // (RAM read register followed by the output hold register).
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_d     = start_q;
        post_d      = post_q;
        ld_cnt_d    = ld_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        pre_d       = pre_q;
        ram_vld_d   = ram_vld_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        overrun_d   = overrun_q;
        freqbin_d   = freqbin_q;
        out_data_d  = out_data_q;
        ram_we_c    = 1'b0;
        rd_en_c     = 1'b0;
        out_load_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    pre_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (sample_valid) begin
                    ram_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDRW'(1);
                    if (pre_q != PCW'(PRE)) pre_d = pre_q + PCW'(1);
                    if (eventDetected && (pre_q == PCW'(PRE))) begin
                        start_d   = wr_ptr_q - ADDRW'(PRE);
                        freqbin_d = freqbin;
                        post_d    = ADDRW'(POST);
                        rd_cnt_d  = '0;
                        ld_cnt_d  = '0;
                        ram_vld_d = 1'b0;
                        state_d   = (POST == 0) ? ST_DRAIN : ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    ram_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDRW'(1);
                    post_d   = post_q - ADDRW'(1);
                    if (post_q == ADDRW'(1)) state_d = ST_DRAIN;
                    if (eventDetected) overrun_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (sample_valid && eventDetected) overrun_d = 1'b1;
                out_load_c = ram_vld_q && (!out_valid_q || out_ready);
                rd_en_c    = !rd_cnt_q[ADDRW] && (!ram_vld_q || out_load_c);
                if (rd_en_c) rd_cnt_d = rd_cnt_q + (ADDRW+1)'(1);
                ram_vld_d = rd_en_c || (ram_vld_q && !out_load_c);
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) state_d = ST_IDLE;
                end
                if (out_load_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ram_rdata;
                    out_first_d = (ld_cnt_q == '0);
                    out_last_d  = (ld_cnt_q == ADDRW'(DEPTH - 1));
                    ld_cnt_d    = ld_cnt_q + ADDRW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            start_q     <= '0;
            post_q      <= '0;
            ld_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pre_q       <= '0;
            ram_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            freqbin_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_q     <= start_d;
            post_q      <= post_d;
            ld_cnt_q    <= ld_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pre_q       <= pre_d;
            ram_vld_q   <= ram_vld_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
            freqbin_q   <= freqbin_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_first   = out_first_q;
    assign out_last    = out_last_q;
    assign out_freqbin = freqbin_q;
    assign state       = state_q;
    assign overrun     = overrun_q;

endmodule
